ex_mem_lsu: RTL and testbench
=============================

// Module: ex_mem_lsu
// PURPOSE
//  EX/MEM pipeline register with integrated L1 data memory and load/store unit for the RV64I core.
//  Adds sub-dword loads/stores (RV64I funct3), sign/zero extension, byte-enable writes,
//  misalignment and range faults, and a pipeline stall hold. Sits between the EX stage and MEM/WB.
// PARAMETERS
//  XLEN        64      data/address width (fixed 64 for RV64I; must be 64)
//  DEPTH       512     data memory depth in XLEN-bit words (power of 2; 512 = 4 KB)
//  BASE_ADDR   64'h0   byte address of word 0; valid range [BASE_ADDR, BASE_ADDR+DEPTH*8)
// PORTS
//  clk              in   1     clock
//  rstn             in   1     asynchronous active-low reset
//  stall            in   1     hold all stage registers; suppress memory write
//  flush            in   1     squash EX instruction (bubble into MEM)
//  memread_ex       in   1     load in EX
//  memwrite_ex      in   1     store in EX
//  memtoreg_ex      in   1     WB selects load data
//  regwrite_ex      in   1     instruction writes rd
//  funct3_ex        in   3     access size/sign (RV64I load/store funct3)
//  dst_ex           in   5     rd index
//  aluresult_ex     in   XLEN  effective byte address / ALU result
//  storedata_ex     in   XLEN  forwarded rs2 store data (low bytes used)
//  pcadd4_ex        in   XLEN  PC+4
//  memread_mem, memtoreg_mem, regwrite_mem  out 1   registered controls
//  dst_mem          out  5     registered rd
//  aluresult_mem    out  XLEN  registered address/result
//  pcadd4_mem       out  XLEN  registered PC+4
//  loaddata_mem     out  XLEN  extended load data (valid when memread_mem)
//  load_fault_mem   out  1     load misaligned/out-of-range/illegal funct3
//  store_fault_mem  out  1     store misaligned/out-of-range/illegal funct3
//  fault_addr_mem   out  XLEN  faulting byte address (0 when no fault)
// BEHAVIOUR
//  Reset (async): all outputs and internal stage regs 0. Memory contents not reset (init 0 at t0).
//  Priority per posedge: reset > flush > stall > normal advance.
//  Normal: all *_ex fields register into *_mem; 1-cycle latency EX->MEM for every output.
//  Flush: memread/memtoreg/regwrite_mem <=0, faults <=0, fault_addr <=0; data fields still load;
//   memory write suppressed (squashed store never commits).
//  Stall: every stage register holds; memory write suppressed; memory read result held.
//  Size: funct3[1:0] 00=B,01=H,10=W,11=D; funct3[2]=1 zero-extend. Loads: 111 illegal.
//   Stores: funct3[2]=1 illegal.
//  Align: fault if addr[0] for H; addr[1:0]!=0 for W; addr[2:0]!=0 for D.
//  Range: fault if addr<BASE_ADDR or addr>=BASE_ADDR+DEPTH*8. Index=(addr-BASE_ADDR)>>3.
//  Fault applies only when memread_ex or memwrite_ex. On fault: no memory write, loaddata_mem=0,
//   regwrite_mem<=0, matching *_fault_mem<=1, fault_addr_mem<=aluresult_ex; others advance normally.
//  Store: byte enables from size and addr[2:0]; storedata lanes replicated to target byte lane;
//   unaffected bytes of the word unchanged.
//  Load: full word read synchronously at the EX->MEM edge; size, sign and addr[2:0] registered
//   alongside; loaddata_mem = selected lane, sign/zero extended to XLEN (combinational off regs).
//  Load with memread_ex=0: loaddata_mem=0.
//  Store at edge N then load same word at edge N+1 returns new data (no bypass needed).
//  memread_ex & memwrite_ex both 1: illegal from decoder; store takes effect, load data 0.
//  Reset mid-operation: in-flight store at reset edge is dropped; outputs 0 immediately.
// TESTING
//  SD 0x1122334455667788 @0x10, then LD @0x10 -> loaddata_mem=0x1122334455667788 next cycle.
//  SB 0xAB @0x13 over above, LB @0x13 -> 0xFFFF_FFFF_FFFF_FFAB; LBU -> 0xAB; LD -> 0x11223344AB667788.
//  LW @0x12 -> load_fault_mem=1, fault_addr_mem=0x12, regwrite_mem=0; SD @0x1000 (DEPTH=512) ->
//   store_fault_mem=1, memory unchanged.
//  stall=1 with SD pending for 3 cycles -> *_mem outputs frozen, write occurs once after release.
//  flush=1 with SW 0xDEADBEEF @0x20 -> regwrite_mem=0, LW @0x20 afterward returns prior value.
//  rstn pulled low mid-stream asynchronously -> all outputs 0 before next clk edge.

Source files
------------

// File: rtl/ex_mem_lsu.sv
// EX/MEM pipeline register with an integrated L1 data memory and RV64I load/store unit.
// Sub-dword stores use byte enables; loads are extended combinationally from the registered word.
module ex_mem_lsu #(
    parameter int          XLEN      = 64,
    parameter int          DEPTH     = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    input  logic            memread_ex,
    input  logic            memwrite_ex,
    input  logic            memtoreg_ex,
    input  logic            regwrite_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [4:0]      dst_ex,
    input  logic [XLEN-1:0] aluresult_ex,
    input  logic [XLEN-1:0] storedata_ex,
    input  logic [XLEN-1:0] pcadd4_ex,
    output logic            memread_mem,
    output logic            memtoreg_mem,
    output logic            regwrite_mem,
    output logic [4:0]      dst_mem,
    output logic [XLEN-1:0] aluresult_mem,
    output logic [XLEN-1:0] pcadd4_mem,
    output logic [XLEN-1:0] loaddata_mem,
    output logic            load_fault_mem,
    output logic            store_fault_mem,
    output logic [XLEN-1:0] fault_addr_mem
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] mem_rdata_reg;
    logic [2:0]      ld_funct3_reg;
    logic            ld_valid_reg;

    logic [XLEN-3:0] offset_word;
    logic            out_of_range;
    logic            misalign;
    logic            load_fault_next;
    logic            store_fault_next;
    logic            fault_next;
    logic            mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [7:0]      byte_en;
    logic [XLEN-1:0] store_lane;
    logic [XLEN-1:0] load_lane;

    // Word-granular offset; the extra top bit is the borrow, i.e. address below BASE_ADDR.
    assign offset_word  = {1'b0, aluresult_ex[XLEN-1:3]} - {1'b0, BASE_ADDR[XLEN-1:3]};
    assign out_of_range = offset_word[XLEN-3] | (|offset_word[XLEN-4:IDX_W]);
    assign mem_idx      = offset_word[IDX_W-1:0];

    always_comb begin
        misalign = 1'b0;
        byte_en  = 8'h00;
        case (funct3_ex[1:0])
            2'b00: begin
                misalign = 1'b0;
                byte_en  = 8'h01 << aluresult_ex[2:0];
            end
            2'b01: begin
                misalign = aluresult_ex[0];
                byte_en  = 8'h03 << aluresult_ex[2:0];
            end
            2'b10: begin
                misalign = |aluresult_ex[1:0];
                byte_en  = 8'h0F << aluresult_ex[2:0];
            end
            default: begin
                misalign = |aluresult_ex[2:0];
                byte_en  = 8'hFF;
            end
        endcase
    end

    assign load_fault_next  = memread_ex  & ((funct3_ex == 3'b111) | misalign | out_of_range);
    assign store_fault_next = memwrite_ex & (funct3_ex[2] | misalign | out_of_range);
    assign fault_next       = load_fault_next | store_fault_next;
    // rstn in the enable drops a store that is in flight while reset is asserted.
    assign mem_we           = memwrite_ex & ~fault_next & ~stall & ~flush & rstn;

    // Replicate the low store bytes into every lane so the enables pick the right one.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_store_lane
            always_comb begin
                case (funct3_ex[1:0])
                    2'b00:   store_lane[gi*8 +: 8] = storedata_ex[7:0];
                    2'b01:   store_lane[gi*8 +: 8] = storedata_ex[(gi%2)*8 +: 8];
                    2'b10:   store_lane[gi*8 +: 8] = storedata_ex[(gi%4)*8 +: 8];
                    default: store_lane[gi*8 +: 8] = storedata_ex[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[mem_idx][b*8 +: 8] <= store_lane[b*8 +: 8];
            end
        end
        if (!stall) mem_rdata_reg <= mem[mem_idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memread_mem     <= 1'b0;
            memtoreg_mem    <= 1'b0;
            regwrite_mem    <= 1'b0;
            dst_mem         <= '0;
            aluresult_mem   <= '0;
            pcadd4_mem      <= '0;
            load_fault_mem  <= 1'b0;
            store_fault_mem <= 1'b0;
            fault_addr_mem  <= '0;
            ld_funct3_reg   <= '0;
            ld_valid_reg    <= 1'b0;
        end else if (flush) begin
            memread_mem     <= 1'b0;
            memtoreg_mem    <= 1'b0;
            regwrite_mem    <= 1'b0;
            dst_mem         <= dst_ex;
            aluresult_mem   <= aluresult_ex;
            pcadd4_mem      <= pcadd4_ex;
            load_fault_mem  <= 1'b0;
            store_fault_mem <= 1'b0;
            fault_addr_mem  <= '0;
            ld_funct3_reg   <= funct3_ex;
            ld_valid_reg    <= 1'b0;
        end else if (!stall) begin
            memread_mem     <= memread_ex;
            memtoreg_mem    <= memtoreg_ex;
            regwrite_mem    <= regwrite_ex & ~fault_next;
            dst_mem         <= dst_ex;
            aluresult_mem   <= aluresult_ex;
            pcadd4_mem      <= pcadd4_ex;
            load_fault_mem  <= load_fault_next;
            store_fault_mem <= store_fault_next;
            fault_addr_mem  <= fault_next ? aluresult_ex : '0;
            ld_funct3_reg   <= funct3_ex;
            // A simultaneous store wins; the load half returns zero.
            ld_valid_reg    <= memread_ex & ~memwrite_ex & ~fault_next;
        end
    end

    assign load_lane = mem_rdata_reg >> {aluresult_mem[2:0], 3'b000};

    always_comb begin
        loaddata_mem = '0;
        if (ld_valid_reg) begin
            case (ld_funct3_reg)
                3'b000:  loaddata_mem = {{(XLEN-8){load_lane[7]}}, load_lane[7:0]};
                3'b001:  loaddata_mem = {{(XLEN-16){load_lane[15]}}, load_lane[15:0]};
                3'b010:  loaddata_mem = {{(XLEN-32){load_lane[31]}}, load_lane[31:0]};
                3'b011:  loaddata_mem = load_lane;
                3'b100:  loaddata_mem = {{(XLEN-8){1'b0}}, load_lane[7:0]};
                3'b101:  loaddata_mem = {{(XLEN-16){1'b0}}, load_lane[15:0]};
                3'b110:  loaddata_mem = {{(XLEN-32){1'b0}}, load_lane[31:0]};
                default: loaddata_mem = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed bench for ex_mem_lsu: sub-dword loads/stores, faults, stall, flush and async reset.
module tb_ex_mem_lsu;
    logic        clk = 1'b0;
    logic        rstn, stall, flush;
    logic        memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex;
    logic [2:0]  funct3_ex;
    logic [4:0]  dst_ex;
    logic [63:0] aluresult_ex, storedata_ex, pcadd4_ex;
    logic        memread_mem, memtoreg_mem, regwrite_mem;
    logic [4:0]  dst_mem;
    logic [63:0] aluresult_mem, pcadd4_mem, loaddata_mem, fault_addr_mem;
    logic        load_fault_mem, store_fault_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_lsu #(.XLEN(64), .DEPTH(512), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
        .funct3_ex(funct3_ex), .dst_ex(dst_ex), .aluresult_ex(aluresult_ex),
        .storedata_ex(storedata_ex), .pcadd4_ex(pcadd4_ex),
        .memread_mem(memread_mem), .memtoreg_mem(memtoreg_mem),
        .regwrite_mem(regwrite_mem), .dst_mem(dst_mem),
        .aluresult_mem(aluresult_mem), .pcadd4_mem(pcadd4_mem),
        .loaddata_mem(loaddata_mem), .load_fault_mem(load_fault_mem),
        .store_fault_mem(store_fault_mem), .fault_addr_mem(fault_addr_mem)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, got);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [4:0] dst, input logic [63:0] addr, input logic [63:0] sd);
        memread_ex   = mr;
        memwrite_ex  = mw;
        memtoreg_ex  = mr;
        regwrite_ex  = mr;
        funct3_ex    = f3;
        dst_ex       = dst;
        aluresult_ex = addr;
        storedata_ex = sd;
        pcadd4_ex    = 64'h100 + addr;
    endtask

    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [4:0] dst, input logic [63:0] addr, input logic [63:0] sd);
        drive(mr, mw, f3, dst, addr, sd);
        step();
    endtask

    initial begin
        rstn  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 5'd0, 64'h0, 64'h0);
        repeat (2) step();
        check_val("rst_regwrite", {63'b0, regwrite_mem}, 64'h0);
        check_val("rst_loaddata", loaddata_mem, 64'h0);
        check_val("rst_faultaddr", fault_addr_mem, 64'h0);
        check_val("rst_faults", {62'b0, load_fault_mem, store_fault_mem}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Seed known words
        issue(1'b0, 1'b1, 3'b011, 5'd0, 64'h00, 64'h0A0A0A0A0A0A0A0A);
        issue(1'b0, 1'b1, 3'b011, 5'd0, 64'h08, 64'h0808080808080808);
        issue(1'b0, 1'b1, 3'b010, 5'd0, 64'h0C, 64'h00000000CAFEF00D);
        issue(1'b0, 1'b1, 3'b011, 5'd0, 64'h10, 64'h1122334455667788);
        check_val("sd_nofault", {63'b0, store_fault_mem}, 64'h0);

        issue(1'b1, 1'b0, 3'b011, 5'd5, 64'h10, 64'h0);
        check_val("ld_10", loaddata_mem, 64'h1122334455667788);
        check_val("ld_dst", {59'b0, dst_mem}, 64'd5);
        check_val("ld_regwrite", {63'b0, regwrite_mem}, 64'h1);
        check_val("ld_pcadd4", pcadd4_mem, 64'h110);

        issue(1'b0, 1'b1, 3'b000, 5'd0, 64'h13, 64'hFFFFFFFFFFFFFFAB);
        issue(1'b1, 1'b0, 3'b000, 5'd1, 64'h13, 64'h0);
        check_val("lb_13", loaddata_mem, 64'hFFFFFFFFFFFFFFAB);
        issue(1'b1, 1'b0, 3'b100, 5'd1, 64'h13, 64'h0);
        check_val("lbu_13", loaddata_mem, 64'h00000000000000AB);
        issue(1'b1, 1'b0, 3'b011, 5'd1, 64'h10, 64'h0);
        check_val("ld_after_sb", loaddata_mem, 64'h11223344AB667788);
        issue(1'b1, 1'b0, 3'b001, 5'd1, 64'h12, 64'h0);
        check_val("lh_12", loaddata_mem, 64'hFFFFFFFFFFFFAB66);
        issue(1'b1, 1'b0, 3'b101, 5'd1, 64'h12, 64'h0);
        check_val("lhu_12", loaddata_mem, 64'h000000000000AB66);

        issue(1'b0, 1'b1, 3'b001, 5'd0, 64'h16, 64'h000000001234BEEF);
        issue(1'b1, 1'b0, 3'b010, 5'd1, 64'h14, 64'h0);
        check_val("lw_14", loaddata_mem, 64'hFFFFFFFFBEEF3344);
        issue(1'b1, 1'b0, 3'b110, 5'd1, 64'h14, 64'h0);
        check_val("lwu_14", loaddata_mem, 64'h00000000BEEF3344);
        issue(1'b1, 1'b0, 3'b011, 5'd1, 64'h08, 64'h0);
        check_val("ld_08_sw", loaddata_mem, 64'hCAFEF00D08080808);

        // Faults
        issue(1'b1, 1'b0, 3'b010, 5'd3, 64'h12, 64'h0);
        check_val("lw_mis_fault", {63'b0, load_fault_mem}, 64'h1);
        check_val("lw_mis_addr", fault_addr_mem, 64'h12);
        check_val("lw_mis_regwrite", {63'b0, regwrite_mem}, 64'h0);
        check_val("lw_mis_data", loaddata_mem, 64'h0);
        issue(1'b0, 1'b1, 3'b011, 5'd0, 64'h1000, 64'h000000000000FFFF);
        check_val("sd_oor_fault", {63'b0, store_fault_mem}, 64'h1);
        check_val("sd_oor_addr", fault_addr_mem, 64'h1000);
        issue(1'b1, 1'b0, 3'b011, 5'd1, 64'h00, 64'h0);
        check_val("ld_00_unchanged", loaddata_mem, 64'h0A0A0A0A0A0A0A0A);
        check_val("fault_cleared", fault_addr_mem, 64'h0);
        issue(1'b1, 1'b0, 3'b111, 5'd1, 64'h10, 64'h0);
        check_val("ld_illegal_f3", {63'b0, load_fault_mem}, 64'h1);
        issue(1'b0, 1'b1, 3'b100, 5'd0, 64'h10, 64'h0);
        check_val("st_illegal_f3", {63'b0, store_fault_mem}, 64'h1);
        issue(1'b0, 1'b1, 3'b011, 5'd0, 64'h11, 64'h0);
        check_val("sd_mis_fault", {63'b0, store_fault_mem}, 64'h1);

        // Stall holds the stage and defers the store
        issue(1'b1, 1'b0, 3'b011, 5'd7, 64'h10, 64'h0);
        check_val("ld_pre_stall", loaddata_mem, 64'hBEEF3344AB667788);
        stall = 1'b1;
        drive(1'b0, 1'b1, 3'b011, 5'd9, 64'h20, 64'hCAFEBABE12345678);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("stall%0d_dst", i), {59'b0, dst_mem}, 64'd7);
            check_val($sformatf("stall%0d_data", i), loaddata_mem, 64'hBEEF3344AB667788);
        end
        stall = 1'b0;
        step();
        check_val("unstall_dst", {59'b0, dst_mem}, 64'd9);
        check_val("unstall_data", loaddata_mem, 64'h0);
        issue(1'b1, 1'b0, 3'b011, 5'd1, 64'h20, 64'h0);
        check_val("ld_20_after_stall", loaddata_mem, 64'hCAFEBABE12345678);

        // Flush squashes a store
        flush = 1'b1;
        drive(1'b0, 1'b1, 3'b010, 5'd4, 64'h20, 64'h00000000DEADBEEF);
        regwrite_ex = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_regwrite", {63'b0, regwrite_mem}, 64'h0);
        check_val("flush_alu", aluresult_mem, 64'h20);
        issue(1'b1, 1'b0, 3'b010, 5'd1, 64'h20, 64'h0);
        check_val("lw_20_after_flush", loaddata_mem, 64'h0000000012345678);
        flush = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 5'd1, 64'h12, 64'h0);
        step();
        flush = 1'b0;
        check_val("flush_fault", {63'b0, load_fault_mem}, 64'h0);

        // Read and write both set: store wins, load data zero
        issue(1'b1, 1'b1, 3'b011, 5'd6, 64'h28, 64'h5555AAAA5555AAAA);
        check_val("rw_both_data", loaddata_mem, 64'h0);
        issue(1'b1, 1'b0, 3'b011, 5'd2, 64'h28, 64'h0);
        check_val("ld_28", loaddata_mem, 64'h5555AAAA5555AAAA);

        // Asynchronous reset mid-cycle; store held across the reset edge is dropped
        #3;
        rstn = 1'b0;
        #1;
        check_val("arst_data", loaddata_mem, 64'h0);
        check_val("arst_dst", {59'b0, dst_mem}, 64'd0);
        check_val("arst_alu", aluresult_mem, 64'h0);
        check_val("arst_pcadd4", pcadd4_mem, 64'h0);
        drive(1'b0, 1'b1, 3'b011, 5'd0, 64'h08, 64'hFFFFFFFFFFFFFFFF);
        step();
        drive(1'b0, 1'b0, 3'b000, 5'd0, 64'h0, 64'h0);
        rstn = 1'b1;
        issue(1'b1, 1'b0, 3'b011, 5'd1, 64'h08, 64'h0);
        check_val("ld_08_after_rst", loaddata_mem, 64'hCAFEF00D08080808);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
